clyde_phase_sched: RTL and testbench
====================================

// Module: clyde_phase_sched
// PURPOSE
//  Sequences the Clyde-128 core and key refresher through the two blockcipher phases of a Spook operation.
//  INIT: encrypt the nonce with tweak 0.
//  FINAL: encrypt the shadow to produce the tag, or decrypt the received tag for verification.
//  Drives the datapath mode-routing selects and the Clyde/key-holder handshakes.
//  Returns done, tag-release and tag-verdict handshakes to the top-level mode FSM.
// PARAMETERS
//  REFRESH_EN  1     1: refresh the key sharing before every Clyde run; 0: skip the refresh states.
//  TIMEOUT     4095  Max cycles in RUN before the block flags an error.
//  CNT_W       12    Width of the RUN watchdog counter; must satisfy 2**CNT_W > TIMEOUT.
// PORTS
//  clk                       in   1  clock
//  rst                       in   1  synchronous reset, active high
//  start_init                in   1  request INIT phase; sampled in IDLE only
//  start_final               in   1  request FINAL phase; sampled in IDLE only
//  decrypt                   in   1  operation direction; latched with start_final
//  keyh_rdy_refresh          in   1  key holder has randomness for a refresh
//  keyh_start_refresh        out  1  one-cycle refresh launch pulse
//  clyde_ready_start         in   1  Clyde idle and PRNG seeded
//  clyde_pre_data_in_valid   out  1  one-cycle Clyde launch pulse
//  clyde_pre_data_out_valid  in   1  Clyde result valid (1 cycle)
//  clyde_pre_enable          out  1  Clyde run enable
//  clyde_inverse             out  1  run Clyde inverse
//  initialisation            out  1  tweak 0 select (INIT phase)
//  ctrl_mux_tag_computation  out  1  Clyde input = shadow state
//  ctrl_en_tag_verif         out  1  enable tag comparator
//  tag_is_valid              in   1  comparator result from datapath
//  busy                      out  1  phase in progress
//  op_done                   out  1  one-cycle pulse at INIT completion
//  tag_valid                 out  1  encryption tag ready for encoder
//  tag_ready                 in   1  encoder accepts tag
//  verif_valid               out  1  one-cycle pulse: verdict available
//  verif_ok                  out  1  verdict, held until the next FINAL phase starts
//  error                     out  1  watchdog expired; sticky until rst
// BEHAVIOUR
//  Reset: state=IDLE, every output 0, counter=0, latched phase/decrypt cleared. rst has priority in every state.
//  IDLE: start_init wins if both starts are high; a losing start_final is dropped, not queued.
//    On start: latch phase and dec=decrypt&FINAL.
//    Next state is REF_REQ when REFRESH_EN=1, else WAIT_RDY.
//  REF_REQ: when keyh_rdy_refresh=1, pulse keyh_start_refresh (1 cycle) and go to REF_WAIT.
//  REF_WAIT: stay at least 1 cycle; leave to WAIT_RDY when keyh_rdy_refresh=1.
//  WAIT_RDY: on clyde_ready_start=1 go to LAUNCH.
//  LAUNCH: clyde_pre_data_in_valid=1 for exactly 1 cycle; counter cleared; go to RUN.
//  RUN: counter increments by 1 per cycle.
//    On clyde_pre_data_out_valid:
//      INIT -> DONE
//      FINAL & !dec -> TAG_OUT
//      FINAL & dec -> VERIF
//    If counter==TIMEOUT and no data_out_valid arrives -> ERR. data_out_valid arriving in that same cycle wins.
//  DONE: op_done=1 for 1 cycle; go to IDLE.
//  TAG_OUT: tag_valid=1 until the cycle tag_ready=1 (transfer on tag_valid&tag_ready); then IDLE.
//    tag_ready=1 on the first TAG_OUT cycle transfers in that cycle.
//  VERIF: ctrl_en_tag_verif=1 for exactly 1 cycle; verif_ok<=tag_is_valid sampled in that cycle;
//    verif_valid pulses the following cycle (state POST); then IDLE.
//  ERR: busy=0, error=1, all strobes 0; only rst exits.
//  Level outputs, registered, held from the IDLE-exit cycle through the last non-IDLE cycle of the phase:
//    clyde_pre_enable: high LAUNCH through RUN exit.
//    initialisation: high for INIT.
//    ctrl_mux_tag_computation: high for FINAL & !dec.
//    clyde_inverse: high for FINAL & dec.
//  busy=1 in every state except IDLE and ERR.
//  verif_ok is cleared when a FINAL phase starts.
//  Starts asserted while busy are ignored.
//  Reset mid-run returns to IDLE next cycle with no pulse emitted.
//  Latency (REFRESH_EN=0, ready high): start -> data_in_valid pulse = 2 cycles.
// TESTING
//  INIT, REFRESH_EN=1, rdy_refresh=1, ready_start=1, out_valid 20 cyc after launch
//    -> one refresh pulse, one launch pulse, initialisation=1 throughout, op_done 1 cycle, busy drops.
//  FINAL enc, tag_ready held 0 for 5 cycles
//    -> mux_tag_computation=1, inverse=0, tag_valid held 5 cycles, transfer on 6th, then IDLE.
//  FINAL dec, tag_is_valid=1, then a second run with tag_is_valid=0
//    -> inverse=1, en_tag_verif 1 cycle, verif_ok=1 then 0, one verif_valid pulse each.
//  start_init & start_final in same cycle; start_final pulsed while busy
//    -> only INIT runs, no later FINAL.
//  TIMEOUT=10, out_valid never asserted
//    -> error=1 after 10 RUN cycles, busy=0, sticky; rst clears everything.
//  rst asserted in RUN and in TAG_OUT
//    -> all outputs 0 next cycle; a clean INIT run afterwards.

Source files
------------

// File: rtl/clyde_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module      : clyde_phase_sched
//  Description : Sequences the Clyde-128 core and the key refresher through
//                the INIT (nonce encryption) and FINAL (tag generation or tag
//                verification) blockcipher phases of a Spook operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module clyde_phase_sched #(
    parameter int REFRESH_EN = 1,
    parameter int TIMEOUT    = 4095,
    parameter int CNT_W      = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic start_init,
    input  logic start_final,
    input  logic decrypt,
    input  logic keyh_rdy_refresh,
    output logic keyh_start_refresh,
    input  logic clyde_ready_start,
    output logic clyde_pre_data_in_valid,
    input  logic clyde_pre_data_out_valid,
    output logic clyde_pre_enable,
    output logic clyde_inverse,
    output logic initialisation,
    output logic ctrl_mux_tag_computation,
    output logic ctrl_en_tag_verif,
    input  logic tag_is_valid,
    output logic busy,
    output logic op_done,
    output logic tag_valid,
    input  logic tag_ready,
    output logic verif_valid,
    output logic verif_ok,
    output logic error
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_REF_REQ  = 4'd1,
        S_REF_WAIT = 4'd2,
        S_WAIT_RDY = 4'd3,
        S_LAUNCH   = 4'd4,
        S_RUN      = 4'd5,
        S_DONE     = 4'd6,
        S_TAG_OUT  = 4'd7,
        S_VERIF    = 4'd8,
        S_POST     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] run_cnt;
    logic             phase_final;
    logic             phase_dec;
    logic             take_start;
    logic             final_next;
    logic             dec_next;
    logic             active_next;

    // A start is only honoured from IDLE; start_init wins a tie
    assign take_start  = (state == S_IDLE) && (start_init || start_final);
    assign final_next  = take_start ? !start_init : phase_final;
    assign dec_next    = take_start ? (!start_init && decrypt) : phase_dec;
    assign active_next = (state_next != S_IDLE) && (state_next != S_ERR);

    // Single-cycle strobes and status decoded from the state register
    assign clyde_pre_data_in_valid = (state == S_LAUNCH);
    assign op_done                 = (state == S_DONE);
    assign tag_valid               = (state == S_TAG_OUT);
    assign ctrl_en_tag_verif       = (state == S_VERIF);
    assign verif_valid             = (state == S_POST);
    assign error                   = (state == S_ERR);
    assign busy                    = (state != S_IDLE) && (state != S_ERR);

    // Next-state logic; the refresh launch is issued in the REF_REQ cycle that sees the key holder ready
    always_comb begin
        state_next         = state;
        keyh_start_refresh = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_start) begin
                    state_next = (REFRESH_EN != 0) ? S_REF_REQ : S_WAIT_RDY;
                end
            end
            S_REF_REQ: begin
                if (keyh_rdy_refresh) begin
                    keyh_start_refresh = !rst;
                    state_next         = S_REF_WAIT;
                end
            end
            S_REF_WAIT: begin
                if (keyh_rdy_refresh) begin
                    state_next = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (clyde_ready_start) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                // A result arriving on the timeout cycle still completes the phase
                if (clyde_pre_data_out_valid) begin
                    if (!phase_final) begin
                        state_next = S_DONE;
                    end else if (phase_dec) begin
                        state_next = S_VERIF;
                    end else begin
                        state_next = S_TAG_OUT;
                    end
                end else if (run_cnt == TIMEOUT_CNT) begin
                    state_next = S_ERR;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_TAG_OUT: begin
                if (tag_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_VERIF: begin
                state_next = S_POST;
            end
            S_POST: begin
                state_next = S_IDLE;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase latch, verdict, RUN watchdog and registered datapath selects
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_final              <= 1'b0;
            phase_dec                <= 1'b0;
            verif_ok                 <= 1'b0;
            run_cnt                  <= '0;
            clyde_pre_enable         <= 1'b0;
            initialisation           <= 1'b0;
            ctrl_mux_tag_computation <= 1'b0;
            clyde_inverse            <= 1'b0;
        end else begin
            phase_final <= final_next;
            phase_dec   <= dec_next;
            if (take_start && !start_init) begin
                verif_ok <= 1'b0;
            end else if (state == S_VERIF) begin
                verif_ok <= tag_is_valid;
            end
            // Counter reads 0 in LAUNCH and k in the k-th RUN cycle
            if (state_next == S_LAUNCH) begin
                run_cnt <= '0;
            end else if ((state == S_LAUNCH) || (state == S_RUN)) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            clyde_pre_enable         <= (state_next == S_LAUNCH) || (state_next == S_RUN);
            initialisation           <= active_next && !final_next;
            ctrl_mux_tag_computation <= active_next && final_next && !dec_next;
            clyde_inverse            <= active_next && final_next && dec_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clyde_phase_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clyde_phase_sched
//  Description : Self-checking bench for clyde_phase_sched. Two instances
//                (refresh on / long watchdog, refresh off / TIMEOUT=10) share
//                the directed stimulus; each has its own Clyde and encoder stub
//                and its own behavioural model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clyde_phase_sched;

    localparam int ST_IDLE     = 0;
    localparam int ST_REF_REQ  = 1;
    localparam int ST_REF_WAIT = 2;
    localparam int ST_WAIT_RDY = 3;
    localparam int ST_LAUNCH   = 4;
    localparam int ST_RUN      = 5;
    localparam int ST_DONE     = 6;
    localparam int ST_TAG      = 7;
    localparam int ST_VERIF    = 8;
    localparam int ST_POST     = 9;
    localparam int ST_ERR      = 10;

    logic clk;
    logic rst;
    logic start_init;
    logic start_final;
    logic decrypt;
    logic keyh_rdy_refresh;
    logic clyde_ready_start;
    logic tag_is_valid;

    logic [1:0] keyh_start_refresh;
    logic [1:0] clyde_pre_data_in_valid;
    logic [1:0] clyde_pre_data_out_valid;
    logic [1:0] clyde_pre_enable;
    logic [1:0] clyde_inverse;
    logic [1:0] initialisation;
    logic [1:0] ctrl_mux_tag_computation;
    logic [1:0] ctrl_en_tag_verif;
    logic [1:0] busy;
    logic [1:0] op_done;
    logic [1:0] tag_valid;
    logic [1:0] tag_ready;
    logic [1:0] verif_valid;
    logic [1:0] verif_ok;
    logic [1:0] error;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model per instance
    int c_refresh [2] = '{1, 0};
    int c_timeout [2] = '{4095, 10};
    int m_stage   [2];
    bit m_init    [2];
    bit m_dec     [2];
    bit m_vok     [2];
    int m_runc    [2];

    // Stubs and monitors per instance
    int lat       [2];
    int tag_wait  [2];
    int since     [2] = '{-1, -1};
    int tvc       [2];
    int n_ref     [2];
    int n_launch  [2];
    int n_done    [2];
    int n_tagv    [2];
    int n_vv      [2];
    int launch_cyc[2];
    int err_cyc   [2];

    clyde_phase_sched #(.REFRESH_EN(1), .TIMEOUT(4095), .CNT_W(12)) dut_a (
        .clk(clk), .rst(rst), .start_init(start_init), .start_final(start_final),
        .decrypt(decrypt), .keyh_rdy_refresh(keyh_rdy_refresh),
        .keyh_start_refresh(keyh_start_refresh[0]), .clyde_ready_start(clyde_ready_start),
        .clyde_pre_data_in_valid(clyde_pre_data_in_valid[0]),
        .clyde_pre_data_out_valid(clyde_pre_data_out_valid[0]),
        .clyde_pre_enable(clyde_pre_enable[0]), .clyde_inverse(clyde_inverse[0]),
        .initialisation(initialisation[0]), .ctrl_mux_tag_computation(ctrl_mux_tag_computation[0]),
        .ctrl_en_tag_verif(ctrl_en_tag_verif[0]), .tag_is_valid(tag_is_valid),
        .busy(busy[0]), .op_done(op_done[0]), .tag_valid(tag_valid[0]), .tag_ready(tag_ready[0]),
        .verif_valid(verif_valid[0]), .verif_ok(verif_ok[0]), .error(error[0])
    );

    clyde_phase_sched #(.REFRESH_EN(0), .TIMEOUT(10), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start_init(start_init), .start_final(start_final),
        .decrypt(decrypt), .keyh_rdy_refresh(keyh_rdy_refresh),
        .keyh_start_refresh(keyh_start_refresh[1]), .clyde_ready_start(clyde_ready_start),
        .clyde_pre_data_in_valid(clyde_pre_data_in_valid[1]),
        .clyde_pre_data_out_valid(clyde_pre_data_out_valid[1]),
        .clyde_pre_enable(clyde_pre_enable[1]), .clyde_inverse(clyde_inverse[1]),
        .initialisation(initialisation[1]), .ctrl_mux_tag_computation(ctrl_mux_tag_computation[1]),
        .ctrl_en_tag_verif(ctrl_en_tag_verif[1]), .tag_is_valid(tag_is_valid),
        .busy(busy[1]), .op_done(op_done[1]), .tag_valid(tag_valid[1]), .tag_ready(tag_ready[1]),
        .verif_valid(verif_valid[1]), .verif_ok(verif_ok[1]), .error(error[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Phase progression derived from the operation's rules, one call per clock
    task automatic model_step(input int i);
        if (rst) begin
            m_stage[i] = ST_IDLE;
            m_init[i]  = 1'b0;
            m_dec[i]   = 1'b0;
            m_vok[i]   = 1'b0;
            m_runc[i]  = 0;
        end else begin
            case (m_stage[i])
                ST_IDLE: if (start_init || start_final) begin
                    m_init[i] = start_init;
                    m_dec[i]  = !start_init && decrypt;
                    if (!start_init) m_vok[i] = 1'b0;
                    m_stage[i] = (c_refresh[i] != 0) ? ST_REF_REQ : ST_WAIT_RDY;
                end
                ST_REF_REQ:  if (keyh_rdy_refresh) m_stage[i] = ST_REF_WAIT;
                ST_REF_WAIT: if (keyh_rdy_refresh) m_stage[i] = ST_WAIT_RDY;
                ST_WAIT_RDY: if (clyde_ready_start) m_stage[i] = ST_LAUNCH;
                ST_LAUNCH: begin
                    m_stage[i] = ST_RUN;
                    m_runc[i]  = 1;
                end
                ST_RUN: begin
                    if (clyde_pre_data_out_valid[i])
                        m_stage[i] = m_init[i] ? ST_DONE : (m_dec[i] ? ST_VERIF : ST_TAG);
                    else if (m_runc[i] == c_timeout[i])
                        m_stage[i] = ST_ERR;
                    else
                        m_runc[i]++;
                end
                ST_DONE: m_stage[i] = ST_IDLE;
                ST_TAG:  if (tag_ready[i]) m_stage[i] = ST_IDLE;
                ST_VERIF: begin
                    m_vok[i]   = tag_is_valid;
                    m_stage[i] = ST_POST;
                end
                ST_POST: m_stage[i] = ST_IDLE;
                default: ;
            endcase
        end
    endtask

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin : compare
        int  st;
        bit  act;
        for (int i = 0; i < 2; i++) begin
            st  = m_stage[i];
            act = (st != ST_IDLE) && (st != ST_ERR);
            chk("busy", i, busy[i], act);
            chk("error", i, error[i], st == ST_ERR);
            chk("keyh_start_refresh", i, keyh_start_refresh[i], (st == ST_REF_REQ) && keyh_rdy_refresh && !rst);
            chk("data_in_valid", i, clyde_pre_data_in_valid[i], st == ST_LAUNCH);
            chk("clyde_pre_enable", i, clyde_pre_enable[i], (st == ST_LAUNCH) || (st == ST_RUN));
            chk("initialisation", i, initialisation[i], act && m_init[i]);
            chk("mux_tag_computation", i, ctrl_mux_tag_computation[i], act && !m_init[i] && !m_dec[i]);
            chk("clyde_inverse", i, clyde_inverse[i], act && !m_init[i] && m_dec[i]);
            chk("en_tag_verif", i, ctrl_en_tag_verif[i], st == ST_VERIF);
            chk("op_done", i, op_done[i], st == ST_DONE);
            chk("tag_valid", i, tag_valid[i], st == ST_TAG);
            chk("verif_valid", i, verif_valid[i], st == ST_POST);
            chk("verif_ok", i, verif_ok[i], m_vok[i]);
            if (keyh_start_refresh[i]) n_ref[i]++;
            if (clyde_pre_data_in_valid[i]) begin
                n_launch[i]++;
                launch_cyc[i] = cyc;
            end
            if (op_done[i]) n_done[i]++;
            if (tag_valid[i]) n_tagv[i]++;
            if (verif_valid[i]) n_vv[i]++;
            if (error[i] && (err_cyc[i] < 0)) err_cyc[i] = cyc;
            model_step(i);
        end
        cyc++;
    end

    // Advance one clock, then let the Clyde and encoder stubs react
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (clyde_pre_data_in_valid[i]) since[i] = 0;
            else if (since[i] >= 0) since[i]++;
            clyde_pre_data_out_valid[i] = (lat[i] > 0) && (since[i] == lat[i]);
            if (clyde_pre_data_out_valid[i]) since[i] = -1;
            if (tag_valid[i]) tvc[i]++;
            else tvc[i] = 0;
            tag_ready[i] = tag_valid[i] && (tvc[i] > tag_wait[i]);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        chk_int("idle_within_budget", int'(ok), 1);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            n_ref[i] = 0; n_launch[i] = 0; n_done[i] = 0;
            n_tagv[i] = 0; n_vv[i] = 0; launch_cyc[i] = -1; err_cyc[i] = -1;
        end
    endtask

    task automatic pulse_start(input bit is_init, input bit is_final);
        start_init  = is_init;
        start_final = is_final;
        step();
        start_init  = 1'b0;
        start_final = 1'b0;
    endtask

    initial begin : stimulus
        int s;
        rst = 1'b1; start_init = 1'b0; start_final = 1'b0; decrypt = 1'b0;
        keyh_rdy_refresh = 1'b1; clyde_ready_start = 1'b1; tag_is_valid = 1'b0;
        clyde_pre_data_out_valid = 2'b00; tag_ready = 2'b00;
        lat = '{20, 6}; tag_wait = '{5, 5};
        clear_counts();
        steps(3);
        rst = 1'b0;
        step();
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_error", int'(error), 0);

        // INIT phase
        clear_counts();
        s = cyc;
        pulse_start(1'b1, 1'b0);
        wait_idle(80);
        chk_int("init_refresh_pulses_a", n_ref[0], 1);
        chk_int("init_refresh_pulses_b", n_ref[1], 0);
        chk_int("init_launch_pulses_a", n_launch[0], 1);
        chk_int("init_op_done_a", n_done[0], 1);
        chk_int("init_latency_b", launch_cyc[1] - s, 2);
        chk_int("init_latency_a", launch_cyc[0] - s, 4);

        // FINAL encryption with a slow encoder
        clear_counts();
        decrypt = 1'b0;
        pulse_start(1'b0, 1'b1);
        wait_idle(80);
        chk_int("enc_tag_valid_cycles_a", n_tagv[0], 6);
        chk_int("enc_tag_valid_cycles_b", n_tagv[1], 6);

        // FINAL decryption: good tag, then bad tag
        clear_counts();
        decrypt = 1'b1; tag_is_valid = 1'b1;
        pulse_start(1'b0, 1'b1);
        wait_idle(80);
        chk_int("dec_ok_verdict", int'(verif_ok), 3);
        chk_int("dec_ok_verif_valid_a", n_vv[0], 1);
        tag_is_valid = 1'b0;
        pulse_start(1'b0, 1'b1);
        wait_idle(80);
        chk_int("dec_bad_verdict", int'(verif_ok), 0);
        chk_int("dec_bad_verif_valid_a", n_vv[0], 2);

        // Simultaneous starts, then a start_final while busy
        clear_counts();
        start_init = 1'b1; start_final = 1'b1;
        step();
        start_init = 1'b0; start_final = 1'b0;
        steps(4);
        pulse_start(1'b0, 1'b1);
        wait_idle(80);
        steps(15);
        chk_int("tie_launches_a", n_launch[0], 1);
        chk_int("tie_op_done_a", n_done[0], 1);
        chk_int("tie_no_verdict_a", n_vv[0], 0);
        chk_int("tie_idle_after", int'(busy), 0);

        // Watchdog: Clyde never answers
        clear_counts();
        lat = '{0, 0};
        pulse_start(1'b1, 1'b0);
        steps(25);
        chk_int("to_error_b", int'(error[1]), 1);
        chk_int("to_busy_b", int'(busy[1]), 0);
        chk_int("to_error_a", int'(error[0]), 0);
        chk_int("to_run_cycles_b", err_cyc[1] - launch_cyc[1], 11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk_int("to_cleared_by_rst", int'(error), 0);

        // Reset during RUN, then a clean INIT
        lat = '{20, 6};
        pulse_start(1'b1, 1'b0);
        steps(7);
        chk_int("mid_run_enable_a", int'(clyde_pre_enable[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk_int("run_rst_busy", int'(busy), 0);
        clear_counts();
        pulse_start(1'b1, 1'b0);
        wait_idle(80);
        chk_int("run_rst_clean_done_a", n_done[0], 1);

        // Reset during TAG_OUT, then a clean INIT
        tag_wait = '{50, 50};
        decrypt = 1'b0;
        pulse_start(1'b0, 1'b1);
        for (int k = 0; k < 60 && !tag_valid[0]; k++) step();
        chk_int("tag_reached_a", int'(tag_valid[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk_int("tag_rst_tag_valid", int'(tag_valid), 0);
        tag_wait = '{5, 5};
        clear_counts();
        pulse_start(1'b1, 1'b0);
        wait_idle(80);
        chk_int("tag_rst_clean_done_a", n_done[0], 1);
        chk_int("tag_rst_clean_done_b", n_done[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
